// File: rtl/serv_rst_pkg.sv
// serv_rst_pkg: shared state encoding and counter sizing for the reset sequencer.
package serv_rst_pkg;

    typedef enum logic [1:0] {ST_SYNC, ST_HOLD, ST_PERIPH, ST_RUN} state_t;

    function automatic int cnt_width(input int p, input int c, input int w);
        int m;
        m = p > c ? p : c;
        m = m > w ? m : w;
        return $clog2(m + 1);
    endfunction

    localparam int CNT_W = cnt_width(4, 16, 1024);

endpackage

// File: rtl/serv_rst_sync.sv
// serv_rst_sync: async-assert / sync-deassert reset chain; rst_s_nxt is the value rst_s takes on the next edge.
module serv_rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic rst_s,
    output logic rst_s_nxt
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) chain <= '1;
        else chain <= {chain[SYNC_STAGES-2:0], 1'b0};

    assign rst_s     = chain[SYNC_STAGES-1];
    assign rst_s_nxt = chain[SYNC_STAGES-2];

endmodule

// File: rtl/serv_rst_seq.sv
// serv_rst_seq: staged reset release (peripherals, then core) with soft reset replay.
// Optional watchdog enabled by defining SERV_RST_SEQ_WDT_EN.
module serv_rst_seq
    import serv_rst_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int PERIPH_DELAY = 4,
    parameter int CORE_DELAY   = 16,
    parameter int WDT_CYCLES   = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sreq,
    output logic o_sack,
    output logic o_rst_periph,
    output logic o_rst_core,
    output logic o_ready
`ifdef SERV_RST_SEQ_WDT_EN
    ,
    input  logic i_wdt_kick,
    output logic o_wdt_fired
`endif
);

    localparam int W = cnt_width(PERIPH_DELAY, CORE_DELAY, WDT_CYCLES);
    localparam logic [W-1:0] P_LAST = W'(PERIPH_DELAY - 1);
    localparam logic [W-1:0] C_LAST = W'(CORE_DELAY - 1);

    state_t         state, state_nxt;
    logic [W-1:0]   cnt, cnt_nxt, run_cnt;
    logic           rst_s, rst_s_nxt, expire;

    serv_rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .rst_s     (rst_s),
        .rst_s_nxt (rst_s_nxt)
    );

`ifdef SERV_RST_SEQ_WDT_EN
    localparam logic [W-1:0] W_LAST = W'(WDT_CYCLES - 1);
    assign expire  = state == ST_RUN && cnt == W_LAST && !i_wdt_kick;
    assign run_cnt = i_wdt_kick ? '0 : cnt + 1'b1;
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) o_wdt_fired <= 1'b0;
        else if (expire) o_wdt_fired <= 1'b1;
`else
    assign expire  = 1'b0;
    assign run_cnt = '0;
`endif

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            state <= ST_SYNC;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end

    // ST_SYNC is left on the same edge rst_s falls, so that edge starts the hold count
    always_comb begin
        state_nxt = state == ST_SYNC   ? (rst_s && rst_s_nxt ? ST_SYNC : ST_HOLD)
                  : state == ST_HOLD   ? (cnt == P_LAST ? ST_PERIPH : ST_HOLD)
                  : state == ST_PERIPH ? (cnt == C_LAST ? ST_RUN : ST_PERIPH)
                  : (i_sreq || expire ? ST_HOLD : ST_RUN);
        cnt_nxt   = state_nxt != state ? '0
                  : state == ST_RUN    ? run_cnt
                  : state == ST_SYNC   ? '0
                  : cnt + 1'b1;
    end

    // both resets decode from one next-state value, so core can never release ahead of periph
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            o_rst_periph <= 1'b1;
            o_rst_core   <= 1'b1;
            o_ready      <= 1'b0;
            o_sack       <= 1'b0;
        end else begin
            o_rst_periph <= state_nxt == ST_SYNC || state_nxt == ST_HOLD;
            o_rst_core   <= state_nxt != ST_RUN;
            o_ready      <= state_nxt == ST_RUN;
            o_sack       <= state == ST_RUN && i_sreq;
        end

endmodule
